// File: rtl/ibus_dbus_arbiter.sv
// rtl/ibus_dbus_arbiter.sv - shares one memory bus between the VexRiscv iBus and dBus
//
// Purpose:
//   Forwards iBus/dBus commands one at a time onto a single memory bus. A
//   command that is presented but not accepted locks the grant until its
//   handshake. Every accepted read pushes its source bit into an in-order FIFO.
//   Returning read responses are routed by the FIFO head. Writes produce no
//   response.
//
// Optional feature macro:
//   ARB_ROUND_ROBIN_EN - defined: ties in IDLE alternate between the buses.
//                        undefined: fixed priority, dBus wins ties.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   ibus_cmd_*           iBus command (valid/ready, address, size)
//   ibus_rsp_*           iBus response (valid, data, error)
//   dbus_cmd_*           dBus command (valid/ready, wr, address, data, mask, size)
//   dbus_rsp_*           dBus read response (valid, last, data, error)
//   mem_cmd_*            forwarded command (valid/ready, wr, address, data, mask, size)
//   mem_rsp_*            in-order read response from memory (valid, data, error)
//   err_orphan_rsp       sticky flag: a response arrived with no read outstanding

module ibus_dbus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ibus_cmd_valid,
  output logic                ibus_cmd_ready,
  input  logic [ADDR_W-1:0]   ibus_cmd_address,
  input  logic [2:0]          ibus_cmd_size,
  output logic                ibus_rsp_valid,
  output logic [DATA_W-1:0]   ibus_rsp_data,
  output logic                ibus_rsp_error,

  input  logic                dbus_cmd_valid,
  output logic                dbus_cmd_ready,
  input  logic                dbus_cmd_wr,
  input  logic [ADDR_W-1:0]   dbus_cmd_address,
  input  logic [DATA_W-1:0]   dbus_cmd_data,
  input  logic [DATA_W/8-1:0] dbus_cmd_mask,
  input  logic [2:0]          dbus_cmd_size,
  output logic                dbus_rsp_valid,
  output logic                dbus_rsp_last,
  output logic [DATA_W-1:0]   dbus_rsp_data,
  output logic                dbus_rsp_error,

  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_wr,
  output logic [ADDR_W-1:0]   mem_cmd_address,
  output logic [DATA_W-1:0]   mem_cmd_data,
  output logic [DATA_W/8-1:0] mem_cmd_mask,
  output logic [2:0]          mem_cmd_size,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_error,

  output logic                err_orphan_rsp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(MAX_PENDING);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;        // 0 = iBus, 1 = dBus
  logic               sel;                 // source currently driving mem_cmd_*
  logic               cmd_valid;
  logic               cmd_hs;
  logic               tie_pick;

  logic [MAX_PENDING-1:0] fifo_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fifo_full, fifo_empty, fifo_head;
  logic               push, pop;
  logic               orphan_q;

  logic               i_ok, d_ok;

  // Fullness comes only from registered count, so mem_rsp_* never reaches
  // the command side combinationally.
  assign fifo_full  = (cnt_q == CNT_W'(MAX_PENDING));
  assign fifo_empty = (cnt_q == '0);
  assign fifo_head  = fifo_q[rd_ptr_q];

  // A dBus write needs no FIFO slot, so it stays selectable when full.
  assign i_ok = ibus_cmd_valid && !fifo_full;
  assign d_ok = dbus_cmd_valid && (dbus_cmd_wr || !fifo_full);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;  // source favoured on the next tie (1 = dBus)

  assign tie_pick = rr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b1;
    end else if (cmd_hs) begin
      rr_q <= ~sel;
    end
  end
`else
  assign tie_pick = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel       = 1'b0;
    cmd_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel       = (i_ok && d_ok) ? tie_pick : d_ok;
        cmd_valid = i_ok || d_ok;
        if (cmd_valid && !mem_cmd_ready) begin
          state_d = ST_LOCKED;
          gnt_d   = sel;
        end
      end
      ST_LOCKED: begin
        // The FIFO cannot fill while locked (pushes happen only on a
        // handshake), so the locked read needs no extra blocking check.
        sel       = gnt_q;
        cmd_valid = gnt_q ? dbus_cmd_valid : ibus_cmd_valid;
        if (cmd_valid && mem_cmd_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  assign mem_cmd_valid   = cmd_valid;
  assign mem_cmd_wr      = sel ? dbus_cmd_wr      : 1'b0;
  assign mem_cmd_address = sel ? dbus_cmd_address : ibus_cmd_address;
  assign mem_cmd_data    = sel ? dbus_cmd_data    : '0;
  assign mem_cmd_mask    = sel ? dbus_cmd_mask    : {MASK_W{1'b1}};
  assign mem_cmd_size    = sel ? dbus_cmd_size    : ibus_cmd_size;

  assign cmd_hs         = cmd_valid && mem_cmd_ready;
  assign ibus_cmd_ready = cmd_valid && !sel && mem_cmd_ready;
  assign dbus_cmd_ready = cmd_valid &&  sel && mem_cmd_ready;

  assign push = cmd_hs && !mem_cmd_wr && !fifo_full;
  assign pop  = mem_rsp_valid && !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (mem_rsp_valid && fifo_empty) begin
        orphan_q <= 1'b1;
      end
    end
  end

  assign err_orphan_rsp = orphan_q;

  assign ibus_rsp_valid = pop && !fifo_head;
  assign ibus_rsp_data  = mem_rsp_data;
  assign ibus_rsp_error = mem_rsp_error;
  assign dbus_rsp_valid = pop &&  fifo_head;
  assign dbus_rsp_last  = dbus_rsp_valid;
  assign dbus_rsp_data  = mem_rsp_data;
  assign dbus_rsp_error = mem_rsp_error;

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb/tb_ibus_dbus_arbiter.sv - self-checking bench for ibus_dbus_arbiter

module tb_ibus_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_cmd_valid, ibus_cmd_ready;
  logic [31:0] ibus_cmd_address;
  logic [2:0]  ibus_cmd_size;
  logic        ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_rsp_data;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr;
  logic [31:0] dbus_cmd_address, dbus_cmd_data;
  logic [3:0]  dbus_cmd_mask;
  logic [2:0]  dbus_cmd_size;
  logic        dbus_rsp_valid, dbus_rsp_last, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [31:0] mem_cmd_address, mem_cmd_data;
  logic [3:0]  mem_cmd_mask;
  logic [2:0]  mem_cmd_size;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_data;
  logic        err_orphan_rsp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PENDING(4)) dut (
    .clk(clk), .reset(reset),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_cmd_address(ibus_cmd_address), .ibus_cmd_size(ibus_cmd_size),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data),
    .ibus_rsp_error(ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_mask(dbus_cmd_mask),
    .dbus_cmd_size(dbus_cmd_size),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_last(dbus_rsp_last),
    .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_error(dbus_rsp_error),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_address(mem_cmd_address),
    .mem_cmd_data(mem_cmd_data), .mem_cmd_mask(mem_cmd_mask),
    .mem_cmd_size(mem_cmd_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_error(mem_rsp_error),
    .err_orphan_rsp(err_orphan_rsp)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dwr;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    logic        mr;
    logic        ev;
    logic        ewr;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  em;
    logic        eir;
    logic        edr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    ibus_cmd_valid   = 1'b0;
    ibus_cmd_address = '0;
    ibus_cmd_size    = 3'd2;
    dbus_cmd_valid   = 1'b0;
    dbus_cmd_wr      = 1'b0;
    dbus_cmd_address = '0;
    dbus_cmd_data    = '0;
    dbus_cmd_mask    = 4'hF;
    dbus_cmd_size    = 3'd1;
    mem_cmd_ready    = 1'b1;
    mem_rsp_valid    = 1'b0;
    mem_rsp_data     = '0;
    mem_rsp_error    = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ibus_read(input logic [31:0] addr);
    @(negedge clk);
    ibus_cmd_valid   = 1'b1;
    ibus_cmd_address = addr;
    mem_cmd_ready    = 1'b1;
    #1;
    chk("ird_ready", 32'(ibus_cmd_ready), 32'd1);
    @(posedge clk);
  endtask

  logic [2:0] tie_src;

  initial begin
    vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,  4'h0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,  4'hF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0,  4'hF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h40,  32'h0,  4'h3, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0,  4'h3, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h55, 4'h1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h55, 4'h1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h0,  4'hF, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0,  4'hF, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h204, 32'hAA, 4'hC, 1'b0, 1'b1, 1'b1, 32'h204, 32'hAA, 4'hC, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h208, 32'hBB, 4'h2, 1'b1, 1'b1, 1'b1, 32'h208, 32'hBB, 4'h2, 1'b0, 1'b1};

    // Reset state
    set_idle();
    reset = 1'b1;
    #1;
    chk("rst_mem_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_iready", 32'(ibus_cmd_ready), 32'd0);
    chk("rst_dready", 32'(dbus_cmd_ready), 32'd0);
    chk("rst_irsp", 32'(ibus_rsp_valid), 32'd0);
    chk("rst_drsp", 32'(dbus_rsp_valid), 32'd0);
    chk("rst_orphan", 32'(err_orphan_rsp), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: one fresh cycle after reset per vector
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ibus_cmd_valid   = vecs[i].iv;
      ibus_cmd_address = vecs[i].ia;
      dbus_cmd_valid   = vecs[i].dv;
      dbus_cmd_wr      = vecs[i].dwr;
      dbus_cmd_address = vecs[i].da;
      dbus_cmd_data    = vecs[i].dd;
      dbus_cmd_mask    = vecs[i].dm;
      mem_cmd_ready    = vecs[i].mr;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(mem_cmd_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_iready", i), 32'(ibus_cmd_ready), 32'(vecs[i].eir));
      chk($sformatf("v%0d_dready", i), 32'(dbus_cmd_ready), 32'(vecs[i].edr));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_wr", i), 32'(mem_cmd_wr), 32'(vecs[i].ewr));
        chk($sformatf("v%0d_addr", i), mem_cmd_address, vecs[i].ea);
        chk($sformatf("v%0d_data", i), mem_cmd_data, vecs[i].ed);
        chk($sformatf("v%0d_mask", i), 32'(mem_cmd_mask), 32'(vecs[i].em));
      end
      @(posedge clk);
    end

    // Single iBus read, response two cycles later
    do_reset();
    ibus_cmd_valid   = 1'b1;
    ibus_cmd_address = 32'h100;
    #1;
    chk("b_size", 32'(mem_cmd_size), 32'd2);
    chk("b_mask", 32'(mem_cmd_mask), 32'hF);
    chk("b_wr", 32'(mem_cmd_wr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    #1;
    chk("b_no_cmd", 32'(mem_cmd_valid), 32'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    #1;
    chk("b_irsp_valid", 32'(ibus_rsp_valid), 32'd1);
    chk("b_irsp_data", ibus_rsp_data, 32'hDEADBEEF);
    chk("b_drsp_valid", 32'(dbus_rsp_valid), 32'd0);
    @(posedge clk);

    // Repeated ties between iBus and dBus reads
`ifdef ARB_ROUND_ROBIN_EN
    tie_src = 3'b101;
`else
    tie_src = 3'b111;
`endif
    do_reset();
    ibus_cmd_valid   = 1'b1;
    ibus_cmd_address = 32'h100;
    dbus_cmd_valid   = 1'b1;
    dbus_cmd_address = 32'h300;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("c_addr%0d", k), mem_cmd_address, tie_src[k] ? 32'h300 : 32'h100);
      chk($sformatf("c_dready%0d", k), 32'(dbus_cmd_ready), 32'(tie_src[k]));
      chk($sformatf("c_iready%0d", k), 32'(ibus_cmd_ready), 32'(!tie_src[k]));
      @(posedge clk);
    end
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    dbus_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hA0 + 32'(k);
      #1;
      chk($sformatf("c_drsp%0d", k), 32'(dbus_rsp_valid), 32'(tie_src[k]));
      chk($sformatf("c_irsp%0d", k), 32'(ibus_rsp_valid), 32'(!tie_src[k]));
      @(posedge clk);
    end

    // Locked grant: iBus stalled 3 cycles, dBus arrives in cycle 2
    do_reset();
    ibus_cmd_valid   = 1'b1;
    ibus_cmd_address = 32'h400;
    mem_cmd_ready    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1) begin
        dbus_cmd_valid   = 1'b1;
        dbus_cmd_address = 32'h500;
      end
      mem_cmd_ready = (k == 3);
      #1;
      chk($sformatf("d_valid%0d", k), 32'(mem_cmd_valid), 32'd1);
      chk($sformatf("d_addr%0d", k), mem_cmd_address, 32'h400);
      chk($sformatf("d_mask%0d", k), 32'(mem_cmd_mask), 32'hF);
      chk($sformatf("d_iready%0d", k), 32'(ibus_cmd_ready), 32'(k == 3));
      chk($sformatf("d_dready%0d", k), 32'(dbus_cmd_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    #1;
    chk("d_next_addr", mem_cmd_address, 32'h500);
    chk("d_next_dready", 32'(dbus_cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dbus_cmd_valid = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'h1111;
    #1;
    chk("d_rsp0_i", 32'(ibus_rsp_valid), 32'd1);
    chk("d_rsp0_d", 32'(dbus_rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_data = 32'h2222;
    #1;
    chk("d_rsp1_d", 32'(dbus_rsp_valid), 32'd1);
    chk("d_rsp1_last", 32'(dbus_rsp_last), 32'd1);
    chk("d_rsp1_data", dbus_rsp_data, 32'h2222);
    chk("d_rsp1_i", 32'(ibus_rsp_valid), 32'd0);
    @(posedge clk);

    // Full FIFO: reads block, a dBus write still passes
    do_reset();
    @(posedge clk);
    for (int k = 0; k < 4; k++) ibus_read(32'h600 + 32'(4 * k));
    @(negedge clk);
    ibus_cmd_address = 32'h610;
    #1;
    chk("e_full_valid", 32'(mem_cmd_valid), 32'd0);
    chk("e_full_iready", 32'(ibus_cmd_ready), 32'd0);
    dbus_cmd_valid   = 1'b1;
    dbus_cmd_wr      = 1'b1;
    dbus_cmd_address = 32'h200;
    dbus_cmd_data    = 32'h55;
    dbus_cmd_mask    = 4'h1;
    #1;
    chk("e_wr_valid", 32'(mem_cmd_valid), 32'd1);
    chk("e_wr_wr", 32'(mem_cmd_wr), 32'd1);
    chk("e_wr_addr", mem_cmd_address, 32'h200);
    chk("e_wr_data", mem_cmd_data, 32'h55);
    chk("e_wr_mask", 32'(mem_cmd_mask), 32'h1);
    chk("e_wr_dready", 32'(dbus_cmd_ready), 32'd1);
    chk("e_wr_iready", 32'(ibus_cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dbus_cmd_valid = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'h11;
    #1;
    chk("e_pop_irsp", 32'(ibus_rsp_valid), 32'd1);
    chk("e_pop_data", ibus_rsp_data, 32'h11);
    chk("e_pop_iready", 32'(ibus_cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("e_after_iready", 32'(ibus_cmd_ready), 32'd1);
    chk("e_after_addr", mem_cmd_address, 32'h610);
    @(posedge clk);

    // Orphan response with empty FIFO
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h77;
    #1;
    chk("f_irsp", 32'(ibus_rsp_valid), 32'd0);
    chk("f_drsp", 32'(dbus_rsp_valid), 32'd0);
    chk("f_orphan_pre", 32'(err_orphan_rsp), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("f_orphan_set", 32'(err_orphan_rsp), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("f_orphan_hold", 32'(err_orphan_rsp), 32'd1);
    reset = 1'b1;
    #1;
    chk("f_orphan_clr", 32'(err_orphan_rsp), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset with two reads outstanding
    @(posedge clk);
    ibus_read(32'h700);
    ibus_read(32'h704);
    @(negedge clk);
    ibus_cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("g_mem_valid", 32'(mem_cmd_valid), 32'd0);
    chk("g_iready", 32'(ibus_cmd_ready), 32'd0);
    chk("g_dready", 32'(dbus_cmd_ready), 32'd0);
    chk("g_orphan", 32'(err_orphan_rsp), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    chk("g_irsp", 32'(ibus_rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("g_orphan_set", 32'(err_orphan_rsp), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
